// File: rtl/check_node_min_scheduler.sv
// rtl/check_node_min_scheduler.sv - min-sum LDPC check-node min1/min2/sign scheduler

module comparator_floating_point (
    input  logic [30:0] i_a,
    input  logic [30:0] i_b,
    output logic        o_lt
);
    logic [7:0]  w_exp_a;
    logic [7:0]  w_exp_b;
    logic [22:0] w_mant_a;
    logic [22:0] w_mant_b;

    assign w_exp_a  = i_a[30:23];
    assign w_exp_b  = i_b[30:23];
    assign w_mant_a = i_a[22:0];
    assign w_mant_b = i_b[22:0];

    assign o_lt = (w_exp_a < w_exp_b) || ((w_exp_a <= w_exp_b) && (w_mant_a < w_mant_b));
endmodule

module check_node_min_scheduler #(
    parameter int DEGREE = 6,
    parameter int IDX_W  = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      min1,
    output logic [31:0]      min2,
    output logic [IDX_W-1:0] min1_idx,
    output logic             sign_xor,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    localparam logic [31:0] MAG_MAX = 32'h7FFF_FFFF;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [31:0]       r_min1;
    logic [31:0]       r_min2;
    logic [IDX_W-1:0]  r_min1_idx;
    logic [IDX_W-1:0]  r_count;
    logic              r_sign_xor;

    logic [30:0]       w_mag;
    logic              w_lt1;
    logic              w_lt2;
    logic              w_accept;
    logic              w_last;
    logic              w_init;

    assign w_mag    = in_data[30:0];
    assign w_accept = in_valid && (r_state == S_COLLECT);
    assign w_last   = (r_count == IDX_W'(DEGREE - 1));

    comparator_floating_point u_cmp_min1 (
        .i_a  (w_mag),
        .i_b  (r_min1[30:0]),
        .o_lt (w_lt1)
    );

    comparator_floating_point u_cmp_min2 (
        .i_a  (w_mag),
        .i_b  (r_min2[30:0]),
        .o_lt (w_lt2)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_init      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_COLLECT;
                    w_init      = 1'b1;
                end
            end
            S_COLLECT: begin
                if (w_accept && w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A start together with out_ready chains straight into the next update.
                if (out_ready) begin
                    if (start) begin
                        w_state_nxt = S_COLLECT;
                        w_init      = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_min1     <= MAG_MAX;
            r_min2     <= MAG_MAX;
            r_min1_idx <= '0;
            r_count    <= '0;
            r_sign_xor <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_init) begin
                r_min1     <= MAG_MAX;
                r_min2     <= MAG_MAX;
                r_min1_idx <= '0;
                r_count    <= '0;
                r_sign_xor <= 1'b0;
            end else if (w_accept) begin
                if (w_lt1) begin
                    r_min2     <= r_min1;
                    r_min1     <= {1'b0, w_mag};
                    r_min1_idx <= r_count;
                end else if (w_lt2) begin
                    r_min2 <= {1'b0, w_mag};
                end
                r_sign_xor <= r_sign_xor ^ in_data[31];
                // Leaving COLLECT on the last accept keeps count at DEGREE-1.
                if (!w_last) begin
                    r_count <= r_count + 1'b1;
                end
            end
        end
    end

    assign in_ready  = (r_state == S_COLLECT);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state == S_COLLECT) || (r_state == S_DONE);
    assign min1      = r_min1;
    assign min2      = r_min2;
    assign min1_idx  = r_min1_idx;
    assign sign_xor  = r_sign_xor;
endmodule

// File: tb/tb_check_node_min_scheduler.sv
// tb/tb_check_node_min_scheduler.sv - self-checking bench for check_node_min_scheduler

module tb_check_node_min_scheduler;
    localparam int DEG = 6;
    localparam int IW  = 3;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   min1;
    logic [31:0]   min2;
    logic [IW-1:0] min1_idx;
    logic          sign_xor;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] v_basic[DEG]   = '{32'h40000000, 32'hBE800000, 32'h40400000,
                                    32'h3F000000, 32'h3F400000, 32'hC0800000};
    logic [31:0] v_tie[DEG]     = '{32'h3F800000, 32'h3F800000, 32'h40000000,
                                    32'h40000000, 32'h40000000, 32'h40000000};
    logic [31:0] v_tie_neg[DEG] = '{32'hBF800000, 32'h3F800000, 32'h40000000,
                                    32'h40000000, 32'h40000000, 32'h40000000};
    localparam logic [67:0] RES_BASIC = {32'h3E800000, 32'h3F000000, 3'd1, 1'b0};
    localparam logic [67:0] RES_INIT  = {32'h7FFFFFFF, 32'h7FFFFFFF, 3'd0, 1'b0};

    check_node_min_scheduler #(.DEGREE(DEG), .IDX_W(IW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .min1      (min1),
        .min2      (min2),
        .min1_idx  (min1_idx),
        .sign_xor  (sign_xor),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: sort magnitudes; min1/min2 are the two smallest, min1 position is its first occurrence.
    function automatic logic [67:0] model(input logic [31:0] v[DEG]);
        logic [30:0] q[$];
        logic [30:0] m;
        int          idx;
        logic        s;
        s = 1'b0;
        for (int i = 0; i < DEG; i++) begin
            m = v[i][30:0];
            q.push_back(m);
            s = s ^ v[i][31];
        end
        q.sort();
        idx = 0;
        for (int i = DEG - 1; i >= 0; i--) begin
            m = v[i][30:0];
            if (m == q[0]) idx = i;
        end
        return {1'b0, q[0], 1'b0, q[1], 3'(idx), s};
    endfunction

    function automatic logic [31:0] rand_llr();
        case ($urandom_range(2, 0))
            0:       return $urandom;
            1:       return {1'($urandom), 8'd127 + 8'($urandom_range(1, 0)), 23'($urandom_range(1, 0))};
            default: return {1'($urandom), 8'd120 + 8'($urandom_range(12, 0)), 23'($urandom)};
        endcase
    endfunction

    task automatic rand_vec(output logic [31:0] v[DEG]);
        for (int i = 0; i < DEG; i++) v[i] = rand_llr();
    endtask

    // gap < 0 picks a random bubble length per element; start is pulsed on element start_at.
    task automatic feed(input logic [31:0] v[DEG], input int gap, input int start_at);
        for (int i = 0; i < DEG; i++) begin
            int g;
            g = (gap < 0) ? int'($urandom_range(2, 0)) : gap;
            for (int k = 0; k < g; k++) begin
                in_valid = 1'b0;
                start    = 1'b0;
                in_data  = $urandom;
                total++;
                if ({in_ready, out_valid, busy} !== 3'b101) begin
                    bad++;
                    $display("FAIL feed_bubble_status got=%b exp=101", {in_ready, out_valid, busy});
                end
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = v[i];
            start    = (i == start_at);
            total++;
            if ({in_ready, out_valid, busy} !== 3'b101) begin
                bad++;
                $display("FAIL feed_accept_status elem=%0d got=%b exp=101", i, {in_ready, out_valid, busy});
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_data  = $urandom;
    endtask

    task automatic begin_update();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, min1, min2, min1_idx, sign_xor} !== {3'b101, RES_INIT}) begin
            bad++;
            $display("FAIL start_init got=%b/%h/%h exp=101/7fffffff/7fffffff",
                     {in_ready, out_valid, busy}, min1, min2);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL drain_idle got=%b exp=000", {in_ready, out_valid, busy});
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b1; in_data = 32'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            bad++;
            $display("FAIL reset_status got=%b exp=000", {in_ready, out_valid, busy});
        end
        total++;
        if ({min1, min2, min1_idx, sign_xor} !== RES_INIT) begin
            bad++;
            $display("FAIL reset_regs got=%h exp=%h", {min1, min2, min1_idx, sign_xor}, RES_INIT);
        end
        rst_n = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, min1} !== {3'b000, 32'h7FFFFFFF}) begin
            bad++;
            $display("FAIL idle_ignores_valid got=%b/%h exp=000/7fffffff", {in_ready, out_valid, busy}, min1);
        end
    endtask

    task automatic test_basic();
        begin_update();
        feed(v_basic, 0, -1);
        total++;
        if ({in_ready, out_valid, busy} !== 3'b011) begin
            bad++;
            $display("FAIL basic_done_status got=%b exp=011", {in_ready, out_valid, busy});
        end
        total++;
        if ({min1, min2, min1_idx, sign_xor} !== RES_BASIC) begin
            bad++;
            $display("FAIL basic_result got=%h exp=%h", {min1, min2, min1_idx, sign_xor}, RES_BASIC);
        end
        drain();
    endtask

    task automatic test_ties();
        logic [67:0] exp_r;
        begin_update();
        feed(v_tie, 0, -1);
        exp_r = {32'h3F800000, 32'h3F800000, 3'd0, 1'b0};
        total++;
        if ({out_valid, min1, min2, min1_idx, sign_xor} !== {1'b1, exp_r}) begin
            bad++;
            $display("FAIL ties_result got=%h exp=%h", {out_valid, min1, min2, min1_idx, sign_xor}, {1'b1, exp_r});
        end
        drain();
        begin_update();
        feed(v_tie_neg, 0, -1);
        exp_r = {32'h3F800000, 32'h3F800000, 3'd0, 1'b1};
        total++;
        if ({out_valid, min1, min2, min1_idx, sign_xor} !== {1'b1, exp_r}) begin
            bad++;
            $display("FAIL ties_neg_result got=%h exp=%h", {out_valid, min1, min2, min1_idx, sign_xor}, {1'b1, exp_r});
        end
        drain();
    endtask

    task automatic test_bubbles();
        begin_update();
        feed(v_basic, 2, -1);
        total++;
        if ({out_valid, min1, min2, min1_idx, sign_xor} !== {1'b1, RES_BASIC}) begin
            bad++;
            $display("FAIL bubbles_result got=%h exp=%h", {out_valid, min1, min2, min1_idx, sign_xor}, {1'b1, RES_BASIC});
        end
        drain();
    endtask

    task automatic test_backpressure();
        logic [31:0] v[DEG];
        logic [67:0] exp_r;
        rand_vec(v);
        exp_r = model(v);
        begin_update();
        feed(v, 0, -1);
        for (int c = 0; c < 3; c++) begin
            total++;
            if ({in_ready, out_valid, busy, min1, min2, min1_idx, sign_xor} !== {3'b011, exp_r}) begin
                bad++;
                $display("FAIL backpressure_hold cyc=%0d got=%b/%h exp=011/%h", c,
                         {in_ready, out_valid, busy}, {min1, min2, min1_idx, sign_xor}, exp_r);
            end
            @(negedge clk);
        end
        start = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0; out_ready = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, min1, min2, min1_idx, sign_xor} !== {3'b101, RES_INIT}) begin
            bad++;
            $display("FAIL back_to_back_reinit got=%b/%h exp=101/%h",
                     {in_ready, out_valid, busy}, {min1, min2, min1_idx, sign_xor}, RES_INIT);
        end
        rand_vec(v);
        exp_r = model(v);
        feed(v, 0, -1);
        total++;
        if ({out_valid, min1, min2, min1_idx, sign_xor} !== {1'b1, exp_r}) begin
            bad++;
            $display("FAIL back_to_back_result got=%h exp=%h", {out_valid, min1, min2, min1_idx, sign_xor}, {1'b1, exp_r});
        end
        drain();
    endtask

    task automatic test_reset_mid();
        logic [31:0] v[DEG];
        logic [67:0] exp_r;
        begin_update();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = 32'h3A000000 + 32'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        total++;
        if ({in_ready, out_valid, busy, min1, min2, min1_idx, sign_xor} !== {3'b000, RES_INIT}) begin
            bad++;
            $display("FAIL reset_mid got=%b/%h exp=000/%h",
                     {in_ready, out_valid, busy}, {min1, min2, min1_idx, sign_xor}, RES_INIT);
        end
        rand_vec(v);
        exp_r = model(v);
        begin_update();
        feed(v, 0, -1);
        total++;
        if ({out_valid, min1, min2, min1_idx, sign_xor} !== {1'b1, exp_r}) begin
            bad++;
            $display("FAIL reset_mid_result got=%h exp=%h", {out_valid, min1, min2, min1_idx, sign_xor}, {1'b1, exp_r});
        end
        drain();
    endtask

    task automatic test_ignored();
        start = 1'b1; in_valid = 1'b1; in_data = 32'h00000000;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        total++;
        if ({in_ready, min1} !== {1'b1, 32'h7FFFFFFF}) begin
            bad++;
            $display("FAIL start_cycle_no_accept got=%b/%h exp=1/7fffffff", in_ready, min1);
        end
        feed(v_basic, 1, 2);
        total++;
        if ({out_valid, min1, min2, min1_idx, sign_xor} !== {1'b1, RES_BASIC}) begin
            bad++;
            $display("FAIL start_in_collect got=%h exp=%h", {out_valid, min1, min2, min1_idx, sign_xor}, {1'b1, RES_BASIC});
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total++;
        if ({in_ready, out_valid, busy, min1} !== {3'b011, 32'h3E800000}) begin
            bad++;
            $display("FAIL start_without_ready got=%b/%h exp=011/3e800000", {in_ready, out_valid, busy}, min1);
        end
        drain();
    endtask

    task automatic test_random();
        logic [31:0] v[DEG];
        logic [67:0] exp_r;
        logic        started;
        int          bp;
        started = 1'b0;
        for (int it = 0; it < 30; it++) begin
            rand_vec(v);
            exp_r = model(v);
            if (!started) begin_update();
            feed(v, -1, -1);
            bp = $urandom_range(3, 0);
            for (int c = 0; c <= bp; c++) begin
                total++;
                if ({out_valid, min1, min2, min1_idx, sign_xor} !== {1'b1, exp_r}) begin
                    bad++;
                    $display("FAIL random_result it=%0d got=%h exp=%h", it,
                             {out_valid, min1, min2, min1_idx, sign_xor}, {1'b1, exp_r});
                end
                if (c < bp) @(negedge clk);
            end
            started   = (it != 29) && ($urandom_range(1, 0) == 1);
            start     = started;
            out_ready = 1'b1;
            @(negedge clk);
            start = 1'b0; out_ready = 1'b0;
            total++;
            if ({in_ready, out_valid, busy} !== (started ? 3'b101 : 3'b000)) begin
                bad++;
                $display("FAIL random_handoff it=%0d got=%b exp=%b", it,
                         {in_ready, out_valid, busy}, (started ? 3'b101 : 3'b000));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ties();
        test_bubbles();
        test_backpressure();
        test_reset_mid();
        test_ignored();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
